bsg_fsb_murn_node_sequencer: RTL and testbench

- Master-side stage that sits directly upstream of a MURN gateway on the FSB ring.
- Merges normal host traffic with switch-command packets that it generates itself, so that remote nodes can be brought up (reset, enable, release reset) or shut down (reset, disable) on request.
- Its output feeds the ring link that the gateways on the ring consume.

---
 rtl/bsg_fsb_murn_node_sequencer.sv | 158 +++++++++++++++
 tb/tb_bsg_fsb_murn_node_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_murn_node_sequencer.sv
`default_nettype none
//==============================================================================
// Module  : bsg_fsb_murn_node_sequencer
// Brief   : Merges host FSB traffic with self-generated MURN switch commands
//           that bring a remote node up or shut it down.
// Revision: 1.0
//==============================================================================
module bsg_fsb_murn_node_sequencer #(
    parameter int width_p      = 80,
    parameter int id_width_p   = 4,
    parameter int reset_hold_p = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_v_i,
    input  logic [id_width_p-1:0] start_id_i,
    input  logic                  start_up_i,
    output logic                  start_ready_o,
    input  logic                  data_v_i,
    input  logic [width_p-1:0]    data_i,
    output logic                  data_ready_o,
    output logic                  v_o,
    output logic [width_p-1:0]    data_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [7:0] c_rnenable_cmd        = 8'h01;
    localparam logic [7:0] c_rndisable_cmd       = 8'h02;
    localparam logic [7:0] c_rnreset_enable_cmd  = 8'h04;
    localparam logic [7:0] c_rnreset_disable_cmd = 8'h05;

    localparam int c_cnt_w = (reset_hold_p > 1) ? $clog2(reset_hold_p) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(reset_hold_p - 1);

    typedef struct packed {
        logic [id_width_p-1:0]          destid;
        logic                           cmd;
        logic [7:0]                     opcode;
        logic [width_p-id_width_p-10:0] data;
    } fsb_pkt_s;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_ON  = 3'd1,
        S_EN      = 3'd2,
        S_HOLD    = 3'd3,
        S_RST_OFF = 3'd4,
        S_DIS     = 3'd5
    } state_e;

    state_e                r_state;
    logic [id_width_p-1:0] r_id;
    logic                  r_up;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_lock;
    logic                  r_done;

    logic     w_send;
    logic     w_src_cmd;
    logic     w_cmd_hs;
    logic     w_data_hs;
    logic     w_data_stall;
    logic [7:0] w_opcode;
    fsb_pkt_s w_cmd_pkt;

    assign w_send = (r_state == S_RST_ON) || (r_state == S_EN) ||
                    (r_state == S_RST_OFF) || (r_state == S_DIS);

    // A stalled host packet owns the link until it handshakes.
    assign w_src_cmd = w_send & ~r_lock;

    always_comb begin
        w_opcode = 8'h00;
        case (r_state)
            S_RST_ON:  w_opcode = c_rnreset_enable_cmd;
            S_EN:      w_opcode = c_rnenable_cmd;
            S_RST_OFF: w_opcode = c_rnreset_disable_cmd;
            S_DIS:     w_opcode = c_rndisable_cmd;
            default:   w_opcode = 8'h00;
        endcase
    end

    always_comb begin
        w_cmd_pkt        = '0;
        w_cmd_pkt.destid = r_id;
        w_cmd_pkt.cmd    = 1'b1;
        w_cmd_pkt.opcode = w_opcode;
    end

    assign v_o           = w_src_cmd ? 1'b1 : data_v_i;
    assign data_o        = w_src_cmd ? w_cmd_pkt : data_i;
    assign data_ready_o  = w_src_cmd ? 1'b0 : ready_i;
    assign start_ready_o = (r_state == S_IDLE);
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;

    assign w_cmd_hs     = w_src_cmd & ready_i;
    assign w_data_hs    = ~w_src_cmd & v_o & ready_i;
    assign w_data_stall = ~w_src_cmd & v_o & ~ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_up    <= 1'b0;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_data_hs) begin
                r_lock <= 1'b0;
            end else if (w_data_stall) begin
                r_lock <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_v_i) begin
                        r_id    <= start_id_i;
                        r_up    <= start_up_i;
                        r_state <= S_RST_ON;
                    end
                end
                S_RST_ON: begin
                    if (w_cmd_hs) begin
                        r_state <= r_up ? S_EN : S_DIS;
                    end
                end
                S_EN: begin
                    if (w_cmd_hs) begin
                        r_cnt   <= c_hold_load;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RST_OFF;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RST_OFF, S_DIS: begin
                    if (w_cmd_hs) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_fsb_murn_node_sequencer.sv
`default_nettype none
//==============================================================================
// Module  : tb_bsg_fsb_murn_node_sequencer
// Brief   : Directed self-checking bench for the MURN node sequencer.
// Revision: 1.0
//==============================================================================
module tb_bsg_fsb_murn_node_sequencer;

    localparam int c_w  = 80;
    localparam int c_id = 4;

    localparam logic [7:0] c_op_en     = 8'h01;
    localparam logic [7:0] c_op_dis    = 8'h02;
    localparam logic [7:0] c_op_rst_en = 8'h04;
    localparam logic [7:0] c_op_rst_ds = 8'h05;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start_v;
    logic [c_id-1:0] start_id;
    logic            start_up;
    logic            start_ready;
    logic            data_v;
    logic [c_w-1:0]  data;
    logic            data_ready;
    logic            v;
    logic [c_w-1:0]  data_out;
    logic            ready;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_errors = 0;

    bsg_fsb_murn_node_sequencer #(
        .width_p     (c_w),
        .id_width_p  (c_id),
        .reset_hold_p(4)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_v_i    (start_v),
        .start_id_i   (start_id),
        .start_up_i   (start_up),
        .start_ready_o(start_ready),
        .data_v_i     (data_v),
        .data_i       (data),
        .data_ready_o (data_ready),
        .v_o          (v),
        .data_o       (data_out),
        .ready_i      (ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_w-1:0] obs, input logic [c_w-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_w-1:0] cmd_pkt(input logic [c_id-1:0] id, input logic [7:0] op);
        return {id, 1'b1, op, 67'd0};
    endfunction

    // Advance one clock; inputs are then set and outputs checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        start_v  = 1'b0;
        start_id = '0;
        start_up = 1'b0;
        data_v   = 1'b0;
        data     = '0;
        ready    = 1'b1;
        tick(); tick();
        settle();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_v", v, 0);
        reset_n = 1'b1;
        tick(); settle();
        check("rst_start_ready", start_ready, 1);

        // Bring-up of node 3
        start_v = 1'b1; start_id = 4'd3; start_up = 1'b1;
        settle();
        check("up_start_ready", start_ready, 1);
        check("up_busy_idle", busy, 0);
        tick(); start_v = 1'b0; settle();
        check("up_rst_en_v", v, 1);
        check("up_rst_en_pkt", data_out, cmd_pkt(4'd3, c_op_rst_en));
        check("up_busy", busy, 1);
        check("up_start_ready_busy", start_ready, 0);
        check("up_data_ready_send", data_ready, 0);
        tick(); settle();
        check("up_en_pkt", data_out, cmd_pkt(4'd3, c_op_en));
        check("up_en_v", v, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check("up_hold_v", v, 0);
            check("up_hold_busy", busy, 1);
        end
        tick(); settle();
        check("up_rst_ds_v", v, 1);
        check("up_rst_ds_pkt", data_out, cmd_pkt(4'd3, c_op_rst_ds));
        check("up_rst_ds_done", done, 0);
        tick(); settle();
        check("up_done", done, 1);
        check("up_busy_end", busy, 0);
        check("up_v_end", v, 0);
        tick(); settle();
        check("up_done_pulse", done, 0);

        // Shutdown of node 9
        start_v = 1'b1; start_id = 4'd9; start_up = 1'b0;
        tick(); start_v = 1'b0; settle();
        check("dn_rst_en_pkt", data_out, cmd_pkt(4'd9, c_op_rst_en));
        tick(); settle();
        check("dn_dis_pkt", data_out, cmd_pkt(4'd9, c_op_dis));
        check("dn_dis_v", v, 1);
        tick(); settle();
        check("dn_done", done, 1);
        check("dn_v_after", v, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            check("dn_no_more_cmd", v, 0);
            check("dn_done_low", done, 0);
        end

        // Host packet stalled when the start request arrives
        data_v = 1'b1; data = 80'hABC; ready = 1'b0;
        start_v = 1'b1; start_id = 4'd5; start_up = 1'b0;
        settle();
        check("lk_v0", v, 1);
        check("lk_data0", data_out, 80'hABC);
        tick(); start_v = 1'b0; settle();
        check("lk_data1", data_out, 80'hABC);
        check("lk_busy1", busy, 1);
        tick(); settle();
        check("lk_data2", data_out, 80'hABC);
        check("lk_v2", v, 1);
        tick(); ready = 1'b1; settle();
        check("lk_data3", data_out, 80'hABC);
        check("lk_data_ready3", data_ready, 1);
        tick(); data_v = 1'b0; settle();
        check("lk_rst_en_pkt", data_out, cmd_pkt(4'd5, c_op_rst_en));
        tick(); settle();
        check("lk_dis_pkt", data_out, cmd_pkt(4'd5, c_op_dis));
        tick(); settle();
        check("lk_done", done, 1);

        // Backpressure on ENABLE, then host traffic interleaved in HOLD
        start_v = 1'b1; start_id = 4'd6; start_up = 1'b1;
        tick(); start_v = 1'b0; ready = 1'b1; settle();
        check("bp_rst_en_pkt", data_out, cmd_pkt(4'd6, c_op_rst_en));
        tick(); ready = 1'b0; settle();
        check("bp_en_pkt0", data_out, cmd_pkt(4'd6, c_op_en));
        tick(); settle();
        check("bp_en_pkt1", data_out, cmd_pkt(4'd6, c_op_en));
        check("bp_en_v1", v, 1);
        tick(); ready = 1'b1; settle();
        check("bp_en_pkt2", data_out, cmd_pkt(4'd6, c_op_en));
        for (int i = 0; i < 3; i++) begin
            logic [c_w-1:0] pkt;
            pkt = {4'd1, 1'b1, 8'(8'h10 + i), 67'h123 + 67'(i)};
            tick(); data_v = 1'b1; data = pkt; settle();
            check("il_v", v, 1);
            check("il_data", data_out, pkt);
            check("il_data_ready", data_ready, 1);
        end
        tick(); data_v = 1'b0; settle();
        check("il_hold_idle_v", v, 0);
        tick(); settle();
        check("il_rst_ds_pkt", data_out, cmd_pkt(4'd6, c_op_rst_ds));
        tick(); settle();
        check("il_done", done, 1);

        // Reset while in HOLD
        start_v = 1'b1; start_id = 4'd2; start_up = 1'b1;
        tick(); start_v = 1'b0; settle();
        check("rh_rst_en_pkt", data_out, cmd_pkt(4'd2, c_op_rst_en));
        tick(); settle();
        check("rh_en_pkt", data_out, cmd_pkt(4'd2, c_op_en));
        tick(); settle();
        check("rh_hold_busy", busy, 1);
        reset_n = 1'b0;
        tick(); reset_n = 1'b1; settle();
        check("rh_busy", busy, 0);
        check("rh_done", done, 0);
        check("rh_start_ready", start_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick(); settle();
            check("rh_no_rst_ds", v, 0);
        end
        data_v = 1'b1; data = 80'h5A5A;
        settle();
        check("rh_follow_v", v, 1);
        check("rh_follow_data", data_out, 80'h5A5A);
        tick(); data_v = 1'b0;
        start_v = 1'b1; start_id = 4'd7; start_up = 1'b0;
        settle();
        check("rh_restart_ready", start_ready, 1);
        tick(); start_v = 1'b0; settle();
        check("rh_restart_pkt", data_out, cmd_pkt(4'd7, c_op_rst_en));
        tick(); settle();
        check("rh_restart_dis", data_out, cmd_pkt(4'd7, c_op_dis));
        tick(); settle();
        check("rh_restart_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
